hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RV32 core. It produces the forwarding selects for the execute stage and the stall and flush controls for the fetch, decode and execute pipeline registers. Its `FlushE` output is the `clear` input of the decode-to-execute register. It also holds a post-reset pipeline-flush sequencer and two saturating hazard event counters for performance debug.

## Interface
- `INIT_CYCLES`, default 2: number of cycles after reset release during which the pipeline is force-flushed (legal range 1–15).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Rs1D`, `Rs2D` input 5 each: source register fields of the instruction in decode.
- `Rs1E`, `Rs2E`, `RdE` input 5 each: source and destination fields in execute.
- `RdM`, `RdW` input 5 each: destination fields in memory and writeback.
- `RegWriteM`, `RegWriteW` input 1 each: register-write enables in memory and writeback.
- `ResultSrcE0` input 1: the instruction in execute is a load.
- `PCSrcE` input 1: branch or jump taken, resolved in execute.
- `CntClr` input 1: synchronous clear of both event counters.
- `ForwardAE`, `ForwardBE` output 2 each: ALU operand selects.
  - 00 = register file, 01 = writeback result, 10 = memory-stage ALU result.
- `StallF`, `StallD` output 1 each: hold the PC register and the fetch-to-decode register.
- `FlushD` output 1: clear the fetch-to-decode register.
- `FlushE` output 1: clear the decode-to-execute register.
- `StallCount` output 32: number of load-use stall cycles, registered.
- `FlushCount` output 32: number of taken-branch flush cycles, registered.

## Operation
**Sequencer states**
- `INIT` is entered asynchronously on `reset` low. It holds a 4-bit down-counter loaded with `INIT_CYCLES`.
- `INIT` → `RUN` on the edge where the counter equals 1; otherwise the counter decrements each cycle.
- `RUN` is terminal until the next reset.

**In `INIT`**
- `FlushD` = 1, `FlushE` = 1.
- `StallF` = 0, `StallD` = 0.
- `ForwardAE` = `ForwardBE` = 00.
- Counters do not count.

**Forwarding (`RUN`), A operand; B is identical with `Rs2E`**
- 10 if `RegWriteM` and `RdM` ≠ 0 and `RdM` == `Rs1E`.
- Else 01 if `RegWriteW` and `RdW` ≠ 0 and `RdW` == `Rs1E`.
- Else 00.
- The memory stage wins when both stages match.

**Load-use detection (`RUN`)**
- `lwStall` = `ResultSrcE0` and `RdE` ≠ 0 and (`RdE` == `Rs1D` or `RdE` == `Rs2D`).

**Stall and flush (`RUN`)**
- `StallF` = `StallD` = `lwStall` and not `PCSrcE`. A taken branch has priority, and the stall is suppressed.
- `FlushD` = `PCSrcE`.
- `FlushE` = `lwStall` or `PCSrcE`.

**Counters (`RUN` only, 32-bit)**
- `StallCount` increments on each cycle where `StallD` = 1.
- `FlushCount` increments on each cycle where `PCSrcE` = 1.
- Both saturate at 0xFFFFFFFF and do not wrap.
- `CntClr` sets both to 0 on the next edge and has priority over increment.
- `CntClr` is also honoured in `INIT`.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the state register, with zero-cycle latency, so that they act on the same edge as the hazard.
- Counters and sequencer are registered with one-cycle latency. An event in cycle n is visible on the count output in cycle n+1.

**Values while `reset` is low**
- State = `INIT`, counter = `INIT_CYCLES`.
- `FlushD` = `FlushE` = 1.
- `StallF` = `StallD` = 0.
- `ForwardAE` = `ForwardBE` = 00.
- `StallCount` = `FlushCount` = 0.

**Release and mid-operation reset**
- After `reset` rises, the flush outputs stay high for exactly `INIT_CYCLES` rising edges.
- `RUN` behaviour applies from the cycle after the last of those edges.
- A reset assertion in mid-`RUN` returns to `INIT` immediately (asynchronously) and zeroes the counters.

**Boundary cases**
- Register x0 is never forwarded and never stalls.
- `lwStall` and `PCSrcE` together: `FlushD` = `FlushE` = 1, no stall; `FlushCount` increments, `StallCount` does not.
- A stall longer than one cycle is not generated. The load leaves execute on the flush, so `lwStall` drops on the next cycle.

## Test plan
- **Reset sequence:** assert `reset` low, release with `INIT_CYCLES` = 2 → `FlushD`/`FlushE` = 1 for 2 cycles after release, then 0 with idle inputs; both counts read 0.
- **Forwarding priority:** `Rs1E` = 5, `RdM` = 5, `RdW` = 5, both `RegWrite` = 1 → `ForwardAE` = 10; drop `RegWriteM` → 01; set `RdM` = `RdW` = 0 with `Rs1E` = 0 → 00.
- **Load-use stall:** `ResultSrcE0` = 1, `RdE` = 7, `Rs2D` = 7 → `StallF` = `StallD` = `FlushE` = 1, `FlushD` = 0; next cycle `StallCount` = 1. Repeat with `RdE` = 0 → no stall.
- **Branch flush and priority:** `PCSrcE` = 1 together with a `lwStall` condition → `FlushD` = `FlushE` = 1, `StallF` = 0; `FlushCount` goes +1, `StallCount` unchanged.
- **Saturation and clear:** force `StallCount` near 0xFFFFFFFF via 3 stall cycles from a preloaded 0xFFFFFFFE (bench backdoor) → holds 0xFFFFFFFF; pulse `CntClr` during a stall cycle → 0 next cycle.
- **Mid-run reset:** pull `reset` low asynchronously between clock edges while in `RUN` with counts nonzero → `FlushE` = 1 and counts = 0 before the next edge; `INIT` sequence repeats on release.

Source files
------------

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - hazard controller signal bundle
// Purpose: groups the pipeline-field inputs and the hazard/counter outputs of
//          hazard_unit so the core (master) and the controller (slave) share one port.
// Ports:   master drives decode/execute/memory/writeback fields and CntClr and
//          receives forwarding selects, stall/flush controls and event counts;
//          slave is the mirror image.
interface hazard_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [4:0]  RdM;
    logic [4:0]  RdW;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        ResultSrcE0;
    logic        PCSrcE;
    logic        CntClr;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, CntClr,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, CntClr,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RV32 5-stage pipeline hazard controller
// Purpose: execute-stage forwarding selects, load-use stall, branch flush,
//          post-reset flush sequencer and saturating stall/flush event counters.
// Ports:   clk   - rising-edge clock
//          reset - asynchronous active-low reset
//          hz    - hazard_if.slave: pipeline register fields in, controls and counts out
module hazard_unit #(
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES);

    state_t      r_state;
    logic [3:0]  r_init_cnt;
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    logic        w_run;
    logic        w_lw_stall;
    logic        w_stall;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Memory stage is checked first so the youngest producer wins; x0 is
    // hard-wired zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       rw_m,
        input logic [4:0] rd_m,
        input logic       rw_w,
        input logic [4:0] rd_w
    );
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign w_run = (r_state == ST_RUN);

    always_comb begin
        w_fwd_a    = 2'b00;
        w_fwd_b    = 2'b00;
        w_lw_stall = 1'b0;
        if (w_run) begin
            w_fwd_a    = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
            w_fwd_b    = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
            w_lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                         ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
        end
    end

    // A taken branch squashes the instruction that would have waited, so the
    // stall is pointless and suppressed.
    assign w_stall = w_lw_stall && !hz.PCSrcE;

    assign hz.ForwardAE  = w_fwd_a;
    assign hz.ForwardBE  = w_fwd_b;
    assign hz.StallF     = w_stall;
    assign hz.StallD     = w_stall;
    assign hz.FlushD     = !w_run || hz.PCSrcE;
    assign hz.FlushE     = !w_run || w_lw_stall || hz.PCSrcE;
    assign hz.StallCount = r_stall_count;
    assign hz.FlushCount = r_flush_count;

    // Post-reset sequencer: holds flush for INIT_LOAD edges after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= INIT_LOAD;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == 4'd1) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_init_cnt <= r_init_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Event counters; clear wins over increment and is honoured in any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else if (hz.CntClr) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else if (w_run) begin
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (hz.PCSrcE && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard testbench for hazard_unit
module tb_hazard_unit;
    localparam int IC = 2;

    typedef struct {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, ld, pcsrc, clr;
    } stim_t;

    typedef struct {
        logic [1:0]  fa, fb;
        logic        st, fd, fe;
        logic [31:0] sc, fc;
    } exp_t;

    logic clk;
    logic reset;
    hazard_if hz();

    hazard_unit #(.INIT_CYCLES(IC)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    stim_t       n;
    int          drv_dly  = 1;
    logic [31:0] m_sc     = 32'd0;
    logic [31:0] m_fc     = 32'd0;
    int          m_init   = IC;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every output sample is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ForwardAE",  32'(hz.ForwardAE), 32'(e.fa));
            chk("ForwardBE",  32'(hz.ForwardBE), 32'(e.fb));
            chk("StallF",     32'(hz.StallF),    32'(e.st));
            chk("StallD",     32'(hz.StallD),    32'(e.st));
            chk("FlushD",     32'(hz.FlushD),    32'(e.fd));
            chk("FlushE",     32'(hz.FlushE),    32'(e.fe));
            chk("StallCount", hz.StallCount,     e.sc);
            chk("FlushCount", hz.FlushCount,     e.fc);
        end
    end

    function automatic stim_t idle(input logic rst);
        stim_t s;
        s.rst = rst;
        s.rs1d = 5'd0; s.rs2d = 5'd0; s.rs1e = 5'd0; s.rs2e = 5'd0;
        s.rde = 5'd0;  s.rdm = 5'd0;  s.rdw = 5'd0;
        s.rwm = 1'b0;  s.rww = 1'b0;  s.ld = 1'b0; s.pcsrc = 1'b0; s.clr = 1'b0;
        return s;
    endfunction

    // Applies n for one cycle, queues the hand-computed controls plus the
    // count values expected during this cycle, then advances the count model
    // across the closing edge.
    task automatic step(input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic fd, input logic fe);
        exp_t e;
        @(posedge clk);
        #(drv_dly);
        reset          = n.rst;
        hz.Rs1D        = n.rs1d;
        hz.Rs2D        = n.rs2d;
        hz.Rs1E        = n.rs1e;
        hz.Rs2E        = n.rs2e;
        hz.RdE         = n.rde;
        hz.RdM         = n.rdm;
        hz.RdW         = n.rdw;
        hz.RegWriteM   = n.rwm;
        hz.RegWriteW   = n.rww;
        hz.ResultSrcE0 = n.ld;
        hz.PCSrcE      = n.pcsrc;
        hz.CntClr      = n.clr;
        if (!n.rst) begin
            m_sc   = 32'd0;
            m_fc   = 32'd0;
            m_init = IC;
        end
        e.fa = fa; e.fb = fb; e.st = st; e.fd = fd; e.fe = fe;
        e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
        if (n.rst) begin
            if (n.clr) begin
                m_sc = 32'd0;
                m_fc = 32'd0;
            end else if (m_init == 0) begin
                if (st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
                if (n.pcsrc && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
            end
            if (m_init > 0) m_init--;
        end
    endtask

    initial begin
        reset = 1'b0;
        n = idle(1'b0);
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
        hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
        hz.PCSrcE = 1'b0; hz.CntClr = 1'b0;

        // Reset and release: flush for IC cycles, then quiet.
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n = idle(1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Forwarding priority and x0.
        n.rs1e = 5'd5; n.rdm = 5'd5; n.rdw = 5'd5; n.rwm = 1'b1; n.rww = 1'b1;
        step(2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        n.rwm = 1'b0;
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        n.rdm = 5'd0; n.rdw = 5'd0; n.rs1e = 5'd0; n.rwm = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        n.rs1e = 5'd3; n.rdm = 5'd3; n.rs2e = 5'd9; n.rdw = 5'd9;
        step(2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
        n.rs2e = 5'd3;
        step(2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        n.rww = 1'b0; n.rs1e = 5'd9; n.rdw = 5'd9;
        step(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);

        // Load-use stalls.
        n = idle(1'b1);
        n.ld = 1'b1; n.rde = 5'd7; n.rs2d = 5'd7;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        n = idle(1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        n.ld = 1'b1; n.rde = 5'd7; n.rs1d = 5'd7;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        n.ld = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        n.ld = 1'b1; n.rde = 5'd0; n.rs1d = 5'd0;
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Branch with simultaneous load-use: branch wins.
        n = idle(1'b1);
        n.ld = 1'b1; n.rde = 5'd7; n.rs2d = 5'd7; n.pcsrc = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n = idle(1'b1);
        n.pcsrc = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n = idle(1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Saturation from a backdoor preload, then clear during a stall.
        @(posedge clk);
        #1;
        dut.r_stall_count = 32'hFFFF_FFFE;
        m_sc = 32'hFFFF_FFFE;
        n.ld = 1'b1; n.rde = 5'd4; n.rs1d = 5'd4;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        n.clr = 1'b1;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        n = idle(1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Build nonzero counts, then reset asynchronously mid-cycle.
        n.ld = 1'b1; n.rde = 5'd2; n.rs2d = 5'd2;
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        n = idle(1'b1);
        n.pcsrc = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n = idle(1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drv_dly = 3;
        n = idle(1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        drv_dly = 1;
        n = idle(1'b1);
        n.clr = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n.clr = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n.pcsrc = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        n = idle(1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        repeat (20) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
